// File: rtl/dff_bank_pkg.sv
// Shared types and defaults for the two-requester flip-flop register bank arbiter.
package dff_bank_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

    // Keeps the address bus at least one bit wide for a single-entry bank.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Request/ack bus for requesters A and B; master = requester side, slave = arbiter.
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = addr_w(DEPTH);

    logic             a_req, a_we, a_ack;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_wdata, a_rdata;
    logic             b_req, b_we, b_ack;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] b_wdata, b_rdata;
    logic             busy;

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata, busy
    );
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata, busy
    );
endinterface

// File: rtl/dff_bank.sv
// DEPTH x WIDTH flip-flop storage: async clear, one write port, one combinational read port.
module dff_bank
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic wr_ok, rd_ok;

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end else begin : g_npow2
            assign wr_ok = (32'(waddr) < DEPTH);
            assign rd_ok = (32'(raddr) < DEPTH);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             mem        <= '0;
        else if (we && wr_ok)   mem[waddr] <= wdata;
    end

    assign rdata = rd_ok ? mem[raddr] : '0;
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter serialising single read/write transactions from A and B
// onto one dff_bank through an IDLE -> ACCESS -> RESP sequence.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = addr_w(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    dff_bank_arbiter_if.slave bus
);
    state_t           state, nxt;
    req_id_t          ptr, gnt_id, sel;
    logic             grant;
    logic             lat_we;
    logic [AW-1:0]    lat_addr;
    logic [WIDTH-1:0] lat_wdata, bank_rdata, acc_data;
    logic [WIDTH-1:0] a_rdata_q, b_rdata_q;

    always_comb begin
        nxt   = state;
        grant = 1'b0;
        sel   = ptr;
        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant = 1'b1;
                    nxt   = ACCESS;
                    if (!bus.b_req)      sel = REQ_A;
                    else if (!bus.a_req) sel = REQ_B;
                end
            end
            ACCESS:  nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Snapshot the winner's request so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id    <= REQ_A;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            gnt_id    <= sel;
            lat_we    <= (sel == REQ_A) ? bus.a_we    : bus.b_we;
            lat_addr  <= (sel == REQ_A) ? bus.a_addr  : bus.b_addr;
            lat_wdata <= (sel == REQ_A) ? bus.a_wdata : bus.b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             ptr <= REQ_A;
        else if (state == RESP) ptr <= (gnt_id == REQ_A) ? REQ_B : REQ_A;
    end

    // A write reflects the value just written back to its requester.
    assign acc_data = lat_we ? lat_wdata : bank_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (state == ACCESS) begin
            if (gnt_id == REQ_A) a_rdata_q <= acc_data;
            else                 b_rdata_q <= acc_data;
        end
    end

    dff_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    ((state == ACCESS) && lat_we),
        .waddr (lat_addr),
        .wdata (lat_wdata),
        .raddr (lat_addr),
        .rdata (bank_rdata)
    );

    assign bus.a_ack   = (state == RESP) && (gnt_id == REQ_A);
    assign bus.b_ack   = (state == RESP) && (gnt_id == REQ_B);
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: table of single transactions plus hand-written
// arbitration, latching, mid-transaction reset and streaming sequences.
module tb_dff_bank_arbiter;
    import dff_bank_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.WIDTH(W), .DEPTH(D)) bus ();
    dff_bank_arbiter #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {logic who; logic [7:0] data;} exp_t;
    typedef struct {bit who; bit we; logic [1:0] addr; logic [7:0] wdata; logic [7:0] exp;} vec_t;

    exp_t       exp_q[$];
    exp_t       e;
    vec_t       tbl[13];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [7:0] held_a = '0;
    logic [7:0] held_b = '0;
    int         t1, t2, t3, t4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input bit who);
        return who ? bus.b_ack : bus.a_ack;
    endfunction

    // Scoreboard: every ack pops the oldest expected response.
    always @(negedge clk) begin
        if (bus.a_ack || bus.b_ack) chk("ack_excl", 32'(bus.a_ack & bus.b_ack), 0);
        if (bus.a_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ack_a: got ack, want none");
            end else begin
                e = exp_q.pop_front();
                chk("ack_who_a", 32'(e.who), 0);
                chk("a_rdata", bus.a_rdata, e.data);
                chk("b_rdata_hold", bus.b_rdata, held_b);
                held_a = e.data;
            end
        end
        if (bus.b_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ack_b: got ack, want none");
            end else begin
                e = exp_q.pop_front();
                chk("ack_who_b", 32'(e.who), 1);
                chk("b_rdata", bus.b_rdata, e.data);
                chk("a_rdata_hold", bus.a_rdata, held_a);
                held_b = e.data;
            end
        end
    end

    task automatic drive(input bit who, input bit we, input logic [1:0] addr, input logic [7:0] wd);
        if (!who) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end
    endtask

    task automatic drop(input bit who);
        if (!who) bus.a_req = 1'b0;
        else      bus.b_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        held_a = '0;
        held_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1 of an IDLE cycle; checks busy and exact ack latency.
    task automatic txn(input bit who, input bit we, input logic [1:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp);
        exp_q.push_back({who, exp});
        drive(who, we, addr, wd);
        @(negedge clk); chk("busy_idle", 32'(bus.busy), 0);
        @(negedge clk); chk("busy_access", 32'(bus.busy), 1); chk("ack_early", 32'(ack_of(who)), 0);
        @(negedge clk); chk("busy_resp", 32'(bus.busy), 1);   chk("ack_lat", 32'(ack_of(who)), 1);
        @(posedge clk); #1 drop(who);
    endtask

    task automatic wait_ack(input bit who, input bit drop_after, output int at);
        at = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_of(who)) begin
                at = cyc;
                break;
            end
        end
        n_vec++;
        if (at < 0) begin
            n_bad++;
            $display("FAIL ack_timeout_%s: got no ack, want ack", who ? "b" : "a");
        end
        if (drop_after) begin
            @(posedge clk);
            #1 drop(who);
        end
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;

        tbl[0]  = '{0, 0, 2'd0, 8'h00, 8'h00};
        tbl[1]  = '{0, 0, 2'd1, 8'h00, 8'h00};
        tbl[2]  = '{0, 0, 2'd2, 8'h00, 8'h00};
        tbl[3]  = '{0, 0, 2'd3, 8'h00, 8'h00};
        tbl[4]  = '{0, 1, 2'd2, 8'hA5, 8'hA5};
        tbl[5]  = '{1, 0, 2'd2, 8'h00, 8'hA5};
        tbl[6]  = '{1, 1, 2'd3, 8'h3C, 8'h3C};
        tbl[7]  = '{0, 0, 2'd3, 8'h00, 8'h3C};
        tbl[8]  = '{1, 1, 2'd0, 8'h77, 8'h77};
        tbl[9]  = '{0, 0, 2'd0, 8'h00, 8'h77};
        tbl[10] = '{1, 0, 2'd1, 8'h00, 8'h00};
        tbl[11] = '{0, 1, 2'd2, 8'hC3, 8'hC3};
        tbl[12] = '{1, 0, 2'd2, 8'h00, 8'hC3};

        @(negedge clk);
        chk("rst_a_ack", 32'(bus.a_ack), 0);
        chk("rst_b_ack", 32'(bus.b_ack), 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            txn(tbl[i].who, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

        // Simultaneous writes after reset: A wins, B follows and its value sticks.
        do_reset();
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        drive(0, 1, 2'd1, 8'h11);
        drive(1, 1, 2'd1, 8'h22);
        wait_ack(0, 1, t1);
        wait_ack(1, 1, t2);
        chk("pair_gap", 32'(t2 - t1), 3);
        txn(0, 0, 2'd1, 8'h00, 8'h22);
        // Pointer now favours B.
        exp_q.push_back({1'b1, 8'h22});
        exp_q.push_back({1'b0, 8'h22});
        drive(0, 0, 2'd1, 8'h00);
        drive(1, 0, 2'd1, 8'h00);
        wait_ack(1, 1, t1);
        wait_ack(0, 1, t2);

        // Request changes after grant are ignored.
        exp_q.push_back({1'b0, 8'h66});
        drive(0, 1, 2'd0, 8'h66);
        @(posedge clk); #1;
        bus.a_addr = 2'd3; bus.a_wdata = 8'hFF;
        wait_ack(0, 1, t1);
        txn(0, 0, 2'd0, 8'h00, 8'h66);
        txn(0, 0, 2'd3, 8'h00, 8'h00);

        // Reset during ACCESS of a B write aborts it.
        drive(1, 1, 2'd2, 8'h5A);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drop(1);
        exp_q.delete();
        held_a = '0;
        held_b = '0;
        @(negedge clk);
        chk("abort_b_ack", 32'(bus.b_ack), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_b_rdata", bus.b_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        drive(0, 0, 2'd2, 8'h00);
        drive(1, 0, 2'd2, 8'h00);
        wait_ack(0, 1, t1);
        wait_ack(1, 1, t2);

        // Streaming A; B arriving later wins the next IDLE.
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h00});
        drive(0, 0, 2'd2, 8'h00);
        wait_ack(0, 0, t1);
        wait_ack(0, 0, t2);
        chk("a_period", 32'(t2 - t1), 3);
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b0, 8'h00});
        @(posedge clk); #1;
        drive(1, 0, 2'd2, 8'h00);
        wait_ack(1, 1, t3);
        chk("b_after_stream", 32'(t3 - t2), 3);
        wait_ack(0, 1, t4);
        chk("a_after_b", 32'(t4 - t3), 3);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
